// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-port RAM arbiter.
// The port widths and the timeout default all come from here.
package ram_port_arbiter_pkg;

  localparam int c_ADDR_SIZE     = 16;
  localparam int c_RAM_DATA_SIZE = 128;
  localparam int c_ARB_TIMEOUT   = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the RAM port arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface ram_port_arbiter_if import ram_port_arbiter_pkg::*; #(
  parameter int ADDR_W = c_ADDR_SIZE,
  parameter int DATA_W = c_RAM_DATA_SIZE
) ();

  logic              P0_RD;
  logic              P0_WR;
  logic [ADDR_W-1:0] P0_ADDR;
  logic [DATA_W-1:0] P0_WDATA;
  logic              P0_ACK;
  logic              P0_ERR;
  logic              P1_RD;
  logic              P1_WR;
  logic [ADDR_W-1:0] P1_ADDR;
  logic [DATA_W-1:0] P1_WDATA;
  logic              P1_ACK;
  logic              P1_ERR;
  logic [DATA_W-1:0] RDATA;
  logic              M_RD;
  logic              M_WR;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_WDATA;
  logic [DATA_W-1:0] M_RDATA;
  logic              M_ACK;
  logic              GRANT;

  modport master (
    input  P0_RD, P0_WR, P0_ADDR, P0_WDATA,
    input  P1_RD, P1_WR, P1_ADDR, P1_WDATA,
    input  M_RDATA, M_ACK,
    output P0_ACK, P0_ERR, P1_ACK, P1_ERR, RDATA,
    output M_RD, M_WR, M_ADDR, M_WDATA, GRANT
  );

  modport slave (
    output P0_RD, P0_WR, P0_ADDR, P0_WDATA,
    output P1_RD, P1_WR, P1_ADDR, P1_WDATA,
    output M_RDATA, M_ACK,
    input  P0_ACK, P0_ERR, P1_ACK, P1_ERR, RDATA,
    input  M_RD, M_WR, M_ADDR, M_WDATA, GRANT
  );

endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on contention the port that did not win last time goes.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  assign valid = |req;
  assign sel   = (&req) ? ~last : req[1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the data-cache (port 0) and instruction-cache (port 1) line requests
// onto one memory interface, one transfer at a time, with a timeout abort.
module ram_port_arbiter import ram_port_arbiter_pkg::*; #(
  parameter int ADDR_W  = c_ADDR_SIZE,
  parameter int DATA_W  = c_RAM_DATA_SIZE,
  parameter int TIMEOUT = c_ARB_TIMEOUT
) (
  input  logic               CLK,
  input  logic               RESET_N,
  ram_port_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state_reg, state_next;
  logic              grant_reg, last_reg, err_reg;
  logic              m_rd_reg, m_wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg, rdata_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [1:0]        req;
  logic              pick_valid, pick_sel;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timeout_hit;

  assign req = {bus.P1_RD | bus.P1_WR, bus.P0_RD | bus.P0_WR};

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_reg),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // A simultaneous RD+WR from one requester resolves to a write.
  assign sel_wr    = pick_sel ? bus.P1_WR    : bus.P0_WR;
  assign sel_addr  = pick_sel ? bus.P1_ADDR  : bus.P0_ADDR;
  assign sel_wdata = pick_sel ? bus.P1_WDATA : bus.P0_WDATA;

  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = BUSY;
      BUSY:    if (bus.M_ACK || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      grant_reg <= 1'b0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
      m_rd_reg  <= 1'b0;
      m_wr_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (pick_valid) begin
          grant_reg <= pick_sel;
          addr_reg  <= sel_addr;
          wdata_reg <= sel_wdata;
          m_rd_reg  <= ~sel_wr;
          m_wr_reg  <= sel_wr;
          err_reg   <= 1'b0;
          cnt_reg   <= '0;
        end
        BUSY: begin
          // An acknowledge on the final counted cycle still wins over the abort.
          if (bus.M_ACK) begin
            m_rd_reg <= 1'b0;
            m_wr_reg <= 1'b0;
            if (m_rd_reg) rdata_reg <= bus.M_RDATA;
          end else if (timeout_hit) begin
            m_rd_reg  <= 1'b0;
            m_wr_reg  <= 1'b0;
            err_reg   <= 1'b1;
            rdata_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE:    last_reg <= grant_reg;
        default: ;
      endcase
    end
  end

  assign bus.P0_ACK  = (state_reg == DONE) && !grant_reg;
  assign bus.P1_ACK  = (state_reg == DONE) &&  grant_reg;
  assign bus.P0_ERR  = bus.P0_ACK && err_reg;
  assign bus.P1_ERR  = bus.P1_ACK && err_reg;
  assign bus.RDATA   = rdata_reg;
  assign bus.M_RD    = m_rd_reg;
  assign bus.M_WR    = m_wr_reg;
  assign bus.M_ADDR  = addr_reg;
  assign bus.M_WDATA = wdata_reg;
  assign bus.GRANT   = grant_reg;

endmodule
